// File: rtl/a2d_sched_pkg.sv
// Shared definitions for the A2D conversion scheduler and its battery filter.
package a2d_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      GAP     = 2'd2,
      CAPTURE = 2'd3
   } schedState_t;

   localparam logic [1:0] CH_LFT  = 2'd0;
   localparam logic [1:0] CH_RGHT = 2'd1;
   localparam logic [1:0] CH_BATT = 2'd2;

   localparam logic [11:0] DEF_LOW_THRES = 12'h800;
   localparam logic [11:0] DEF_HYST      = 12'h040;

   // Formed at 13 bits so a high threshold plus hysteresis cannot wrap.
   function automatic logic [12:0] clearLevel(input logic [11:0] thres, input logic [11:0] hyst);
      return {1'b0, thres} + {1'b0, hyst};
   endfunction

endpackage

// File: rtl/a2d_sched_batt.sv
// Four-tap battery average with a priming counter and a hysteresis low-battery flag.
module batt_filt
   import a2d_sched_pkg::*;
#(
   parameter logic [11:0] LOW_THRES = DEF_LOW_THRES,
   parameter logic [11:0] HYST      = DEF_HYST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_smpl,
   input  logic [11:0] i_batt,
   output logic [11:0] o_battAvg,
   output logic        o_battLow
);

   localparam logic [12:0] CLR_LEVEL = clearLevel(LOW_THRES, HYST);

   logic [11:0] r_tap0;
   logic [11:0] r_tap1;
   logic [11:0] r_tap2;
   logic [11:0] r_tap3;
   logic [13:0] r_sum;
   logic [2:0]  r_primeCnt;
   logic        r_evalPend;
   logic        r_battLow;
   logic        w_primed;
   logic [11:0] w_avg;

   assign w_primed = (r_primeCnt == 3'd4);
   assign w_avg    = w_primed ? r_sum[13:2] : 12'h000;

   // The sum may pass through a wrapped value mid-expression, but the true
   // four-sample total always fits in 14 bits, so the modular result is exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap0     <= 12'h000;
         r_tap1     <= 12'h000;
         r_tap2     <= 12'h000;
         r_tap3     <= 12'h000;
         r_sum      <= 14'h0000;
         r_primeCnt <= 3'd0;
      end else if (i_smpl) begin
         r_tap0 <= i_batt;
         r_tap1 <= r_tap0;
         r_tap2 <= r_tap1;
         r_tap3 <= r_tap2;
         r_sum  <= r_sum + {2'b00, i_batt} - {2'b00, r_tap3};
         if (!w_primed) begin
            r_primeCnt <= r_primeCnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evalPend <= 1'b0;
         r_battLow  <= 1'b0;
      end else begin
         r_evalPend <= i_smpl;
         if (r_evalPend && w_primed) begin
            if (w_avg < LOW_THRES) begin
               r_battLow <= 1'b1;
            end else if ({1'b0, w_avg} >= CLR_LEVEL) begin
               r_battLow <= 1'b0;
            end
         end
      end
   end

   assign o_battAvg = w_avg;
   assign o_battLow = r_battLow;

endmodule

// File: rtl/a2d_sched.sv
// Sweep scheduler: three spaced nxt strobes per period, then battery capture and ld_vld.
module a2d_sched
   import a2d_sched_pkg::*;
#(
   parameter bit          fast_sim  = 1'b0,
   parameter int          CNV_GAP   = 2048,
   parameter logic [11:0] LOW_THRES = DEF_LOW_THRES,
   parameter logic [11:0] HYST      = DEF_HYST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwr_up,
   input  logic [11:0] batt,
   output logic        nxt,
   output logic        ld_vld,
   output logic [11:0] batt_avg,
   output logic        batt_low
);

   localparam int TMR_W = fast_sim ? 14 : 20;
   localparam int GAP_W = $clog2(CNV_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CNV_GAP - 1);

   schedState_t      r_state;
   schedState_t      w_nxtState;
   logic [TMR_W-1:0] r_tmr;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] w_gapDec;
   logic [1:0]       r_chan;
   logic [1:0]       w_chanNext;
   logic             r_ldVld;
   logic             w_tmrTerm;
   logic             w_gapDone;
   logic             w_capture;
   logic             w_chanInc;

   assign w_tmrTerm  = &r_tmr;
   assign w_gapDec   = r_gap - GAP_W'(1);
   assign w_gapDone  = (w_gapDec == '0);
   assign w_chanNext = (r_chan == CH_LFT) ? CH_RGHT : CH_BATT;
   assign w_capture  = (r_state == CAPTURE) && pwr_up;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmr <= '0;
      end else if (!pwr_up) begin
         r_tmr <= '0;
      end else begin
         r_tmr <= r_tmr + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxtState;
      end
   end

   // Leaving GAP once the decremented count hits zero puts strobes exactly CNV_GAP apart.
   always_comb begin
      w_nxtState = r_state;
      w_chanInc  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tmrTerm) begin
               w_nxtState = ISSUE;
            end
         end
         ISSUE: begin
            w_nxtState = GAP;
         end
         GAP: begin
            if (w_gapDone) begin
               if (r_chan == CH_BATT) begin
                  w_nxtState = CAPTURE;
               end else begin
                  w_nxtState = ISSUE;
                  w_chanInc  = 1'b1;
               end
            end
         end
         CAPTURE: begin
            w_nxtState = IDLE;
         end
         default: begin
            w_nxtState = IDLE;
         end
      endcase
      if (!pwr_up) begin
         w_nxtState = IDLE;
         w_chanInc  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else if (!pwr_up) begin
         r_gap <= '0;
      end else if (r_state == ISSUE) begin
         r_gap <= GAP_LOAD;
      end else if (r_state == GAP) begin
         r_gap <= w_gapDec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chan <= CH_LFT;
      end else if (!pwr_up || (r_state == CAPTURE)) begin
         r_chan <= CH_LFT;
      end else if (w_chanInc) begin
         r_chan <= w_chanNext;
      end
   end

   // Abort on the capture cycle suppresses both the sample and ld_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ldVld <= 1'b0;
      end else begin
         r_ldVld <= w_capture;
      end
   end

   batt_filt #(
      .LOW_THRES (LOW_THRES),
      .HYST      (HYST)
   ) u_battFilt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_smpl    (w_capture),
      .i_batt    (batt),
      .o_battAvg (batt_avg),
      .o_battLow (batt_low)
   );

   assign nxt    = (r_state == ISSUE);
   assign ld_vld = r_ldVld;

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench: several scheduler instances run side by side so sequencing, filter,
// hysteresis, abort and reset behaviour all fit within five sweep periods.
module tb_a2d_sched;

   logic clk = 1'b0;
   logic rst_n;
   logic rstD;
   logic pwr_up;
   logic pwrD;
   logic [11:0] battA, battB, battC, battD, battE;
   logic nxtA, nxtB, nxtC, nxtD, nxtE;
   logic ldA, ldB, ldC, ldD, ldE;
   logic [11:0] avgA, avgB, avgC, avgD, avgE;
   logic lowA, lowB, lowC, lowD, lowE;

   int errorCount = 0;
   int checkCount = 0;
   int cyc = 0;
   int relCyc = 0;
   int nxtTimesA[$];
   int ldTimesA[$];

   logic [11:0] vecA [5] = '{12'hFFF, 12'h000, 12'hFFF, 12'h001, 12'hFFF};
   logic [11:0] vecB [5] = '{12'h700, 12'h700, 12'h700, 12'h700, 12'hC00};
   logic [11:0] vecC [5] = '{12'h700, 12'h700, 12'h700, 12'h700, 12'hBFF};
   logic [11:0] vecE [5] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h7FF};

   logic [11:0] expAvgA [5] = '{12'h000, 12'h000, 12'h000, 12'h7FF, 12'h7FF};
   logic [11:0] expAvgB [5] = '{12'h000, 12'h000, 12'h000, 12'h700, 12'h840};
   logic [11:0] expAvgC [5] = '{12'h000, 12'h000, 12'h000, 12'h700, 12'h83F};
   logic [11:0] expAvgE [5] = '{12'h000, 12'h000, 12'h000, 12'h800, 12'h7FF};
   bit expLowA [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   bit expLowB [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   bit expLowC [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   bit expLowE [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   a2d_sched #(.fast_sim(1'b1), .CNV_GAP(2048)) dutA (
      .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .batt(battA),
      .nxt(nxtA), .ld_vld(ldA), .batt_avg(avgA), .batt_low(lowA));
   a2d_sched #(.fast_sim(1'b1), .CNV_GAP(2048)) dutB (
      .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .batt(battB),
      .nxt(nxtB), .ld_vld(ldB), .batt_avg(avgB), .batt_low(lowB));
   a2d_sched #(.fast_sim(1'b1), .CNV_GAP(2048)) dutC (
      .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .batt(battC),
      .nxt(nxtC), .ld_vld(ldC), .batt_avg(avgC), .batt_low(lowC));
   a2d_sched #(.fast_sim(1'b1), .CNV_GAP(2048)) dutD (
      .clk(clk), .rst_n(rstD), .pwr_up(pwrD), .batt(battD),
      .nxt(nxtD), .ld_vld(ldD), .batt_avg(avgD), .batt_low(lowD));
   a2d_sched #(.fast_sim(1'b1), .CNV_GAP(2048)) dutE (
      .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .batt(battE),
      .nxt(nxtE), .ld_vld(ldE), .batt_avg(avgE), .batt_low(lowE));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Timestamps of instance A strobes, in cycles since reset release.
   always @(negedge clk) begin
      if (nxtA) nxtTimesA.push_back(cyc - relCyc);
      if (ldA) ldTimesA.push_back(cyc - relCyc);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checkCount++;
      if (got !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
      end
   endtask

   task automatic applyStimulus(input int k);
      battA = vecA[k];
      battB = vecB[k];
      battC = vecC[k];
      battE = vecE[k];
   endtask

   function automatic int nxtAt(input int i);
      return (nxtTimesA.size() > i) ? nxtTimesA[i] : -1;
   endfunction

   function automatic int ldAt(input int i);
      return (ldTimesA.size() > i) ? ldTimesA[i] : -1;
   endfunction

   task automatic waitLdA(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 25000 && !ok; i++) begin
         @(negedge clk);
         if (ldA) ok = 1'b1;
      end
   endtask

   task automatic mainFlow();
      bit ok;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(k);
         waitLdA(ok);
         checkOutput($sformatf("ldA_seen_s%0d", k + 1), ok, 1);
         if (k == 3) begin
            checkOutput("lowA_before_eval", lowA, 0);
            checkOutput("avgA_at_ld", avgA, 12'h7FF);
         end
         repeat (2) @(negedge clk);
         checkOutput($sformatf("avgA_s%0d", k + 1), avgA, expAvgA[k]);
         checkOutput($sformatf("lowA_s%0d", k + 1), lowA, expLowA[k]);
         checkOutput($sformatf("avgB_s%0d", k + 1), avgB, expAvgB[k]);
         checkOutput($sformatf("lowB_s%0d", k + 1), lowB, expLowB[k]);
         checkOutput($sformatf("avgC_s%0d", k + 1), avgC, expAvgC[k]);
         checkOutput($sformatf("lowC_s%0d", k + 1), lowC, expLowC[k]);
         checkOutput($sformatf("avgE_s%0d", k + 1), avgE, expAvgE[k]);
         checkOutput($sformatf("lowE_s%0d", k + 1), lowE, expLowE[k]);
      end
      checkOutput("nxtA_first", nxtAt(0), 16384);
      checkOutput("nxtA_second", nxtAt(1), 18432);
      checkOutput("nxtA_third", nxtAt(2), 20480);
      checkOutput("ldA_first", ldAt(0), 22529);
      checkOutput("nxtA_sweep2", nxtAt(3), 32768);
      checkOutput("ldA_sweep5", ldAt(4), 88065);
      checkOutput("nxtA_total", nxtTimesA.size(), 15);
      checkOutput("ldA_total", ldTimesA.size(), 5);
   endtask

   task automatic abortFlow();
      bit found;
      int seen;
      int nCnt;
      int lCnt;
      int waitCyc;
      found = 1'b0;
      seen = 0;
      for (int i = 0; i < 25000 && !found; i++) begin
         @(negedge clk);
         if (nxtD) seen++;
         if (seen == 2) found = 1'b1;
      end
      checkOutput("nxtD_second_seen", found, 1);
      repeat (10) @(negedge clk);
      pwrD = 1'b0;
      nCnt = 0;
      lCnt = 0;
      for (int i = 0; i < 4500; i++) begin
         @(negedge clk);
         if (nxtD) nCnt++;
         if (ldD) lCnt++;
      end
      checkOutput("abort_nxt_count", nCnt, 0);
      checkOutput("abort_ld_count", lCnt, 0);
      checkOutput("abort_lowD", lowD, 0);
      pwrD = 1'b1;
      found = 1'b0;
      waitCyc = 0;
      for (int i = 0; i < 20000 && !found; i++) begin
         @(negedge clk);
         waitCyc++;
         if (nxtD) found = 1'b1;
      end
      checkOutput("repower_nxt_delay", waitCyc, 16384);
      // Reset lands between clock edges while nxt is high; outputs must drop at once.
      #1 rstD = 1'b0;
      #1;
      checkOutput("arst_nxtD", nxtD, 0);
      checkOutput("arst_ldD", ldD, 0);
      checkOutput("arst_avgD", avgD, 0);
      checkOutput("arst_lowD", lowD, 0);
      repeat (2) @(negedge clk);
      rstD = 1'b1;
      nCnt = 0;
      lCnt = 0;
      for (int i = 0; i < 6500; i++) begin
         @(negedge clk);
         if (nxtD) nCnt++;
         if (ldD) lCnt++;
      end
      checkOutput("post_rst_nxt_count", nCnt, 0);
      checkOutput("post_rst_ld_count", lCnt, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      rstD = 1'b0;
      pwr_up = 1'b0;
      pwrD = 1'b0;
      battA = 12'h000;
      battB = 12'h000;
      battC = 12'h000;
      battD = 12'h100;
      battE = 12'h000;
      #3;
      checkOutput("rst_nxtA", nxtA, 0);
      checkOutput("rst_ldA", ldA, 0);
      checkOutput("rst_avgA", avgA, 0);
      checkOutput("rst_lowA", lowA, 0);
      @(negedge clk);
      relCyc = cyc;
      rst_n = 1'b1;
      rstD = 1'b1;
      pwr_up = 1'b1;
      pwrD = 1'b1;
      $display("[TB] reset released, sweeps running");
      fork
         mainFlow();
         abortFlow();
      join
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Conversion scheduler and battery monitor between the digital core and `A2D_intf`. Each conversion sweep issues three spaced `nxt` strobes, covering the left load cell, the right load cell and the battery, in `A2D_intf`'s round-robin order. After the sweep it flags that fresh load values are ready. It also keeps a 4-sample average of the battery reading and produces a `batt_low` with hysteresis, which drives the piezo and the core.

## Interface
- `fast_sim`, default 0: selects the sweep period. 1 gives 2^14 clocks, 0 gives 2^20 clocks.
- `CNV_GAP`, default 2048: clocks from one `nxt` to the next `nxt`, or to the battery capture. Must exceed one `A2D_intf` SPI transaction.
- `LOW_THRES`, default 12'h800: `batt_low` sets when the battery average is strictly below this value.
- `HYST`, default 12'h040: `batt_low` clears when the average is at or above `LOW_THRES+HYST`.
- `clk`, in, 1: system clock. One clock domain only.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `pwr_up`, in, 1: from `AUTH_blk`. Sweeps run only while this is high.
- `batt`, in, 12: battery reading from `A2D_intf`, unsigned.
- `nxt`, out, 1: one-cycle strobe to `A2D_intf` that starts a conversion.
- `ld_vld`, out, 1: one-cycle pulse when a sweep completes. At that point `lft_ld`, `rght_ld` and `batt` in `A2D_intf` are all fresh.
- `batt_avg`, out, 12: current 4-sample battery average.
- `batt_low`, out, 1: low-battery flag with hysteresis.

## Operation
- **Sweep timer:**
  - Free-running counter of width 14 or 20 bits, chosen by `fast_sim`. It runs only while `pwr_up` is high and is cleared while `pwr_up` is low.
  - When it reaches its terminal count (all ones) with the FSM in IDLE, a sweep starts.
- **FSM states:** IDLE, ISSUE, GAP, CAPTURE.
  - IDLE → ISSUE on the sweep start.
  - ISSUE: assert `nxt` for exactly one cycle and load the gap counter with `CNV_GAP-1`. Next state is GAP.
  - GAP: count down. At zero, if the channel index is below 2, increment it and go to ISSUE. If the index equals 2, go to CAPTURE.
  - CAPTURE: lasts one cycle. Shift `batt` into the filter, pulse `ld_vld`, clear the channel index, return to IDLE.
- **Channel index:** 2 bits, values 0..2 only. 0 is left load, 1 is right load, 2 is battery.
- **Abort:** `pwr_up` low in any state forces IDLE on the next edge.
  - The channel index and gap counter clear, and no `ld_vld` is issued.
  - The filter contents and `batt_low` are retained.
  - Known consequence: `A2D_intf`'s channel pointer may be left mid-rotation. The core ignores load values until the first `ld_vld` after `pwr_up` rises again.
- **Filter:**
  - Four 12-bit registers plus a 14-bit unsigned sum. `batt_avg` is `sum[13:2]` (truncating, no rounding).
  - A primed counter counts up to 4 samples. Until it reaches 4, `batt_avg` reads 0 and `batt_low` is held at 0.
- **Hysteresis:**
  - The comparison is evaluated in the cycle after CAPTURE, once the updated average is available.
  - Set when `batt_avg < LOW_THRES`. Clear when `batt_avg >= LOW_THRES+HYST`. Otherwise hold.
  - `LOW_THRES+HYST` is computed at 13 bits, so it cannot wrap.

## Timing
- **Reset values:** `nxt`=0, `ld_vld`=0, `batt_avg`=0, `batt_low`=0. FSM in IDLE, all counters 0, filter registers 0, primed count 0.
- **Within a sweep:**
  - `nxt` strobes are exactly `CNV_GAP` cycles apart.
  - `ld_vld` comes `CNV_GAP+1` cycles after the third `nxt`.
  - `batt_low` updates 1 cycle after `ld_vld`.
- **Sweep period:** sweeps start exactly 2^14 or 2^20 cycles apart. The required `3*CNV_GAP+3` cycles of sweep fit inside the period, so the timer never wraps while a sweep is active.
- **Simultaneous events:** `pwr_up` falling on the CAPTURE cycle gives abort priority. No capture and no `ld_vld`.

## Structure
- Shared package (the Segway package):
  - FSM state enum.
  - Channel index constants `CH_LFT`, `CH_RGHT`, `CH_BATT`.
  - Default `LOW_THRES` and `HYST`.
- Natural sub-module: `batt_filt`, containing the 4-tap average, primed counter and hysteresis comparator. Its inputs are a sample strobe and `batt`.
- Instantiate inside Digital_Core. Its `nxt` replaces the current source of `nxt`, and its `batt_low` replaces the current source of `batt_low`.

## Test plan
- **Sweep sequencing:** `fast_sim`=1, `pwr_up`=1, `CNV_GAP`=2048. Expect:
  - 3 `nxt` pulses at cycles T, T+2048, T+4096;
  - `ld_vld` at T+6145;
  - next sweep's first `nxt` at T+16384.
- **Priming and low detection:** `batt`=12'h700 for 4 sweeps. Expect `batt_low`=0 after sweeps 1–3, then `batt_avg`=12'h700 and `batt_low`=1 after sweep 4.
- **Hysteresis:** from the low state, hold `batt`=12'h820 for 4 sweeps. `batt_low` stays 1 (12'h820 < 12'h840). Then hold `batt`=12'h840 for 4 sweeps. `batt_low` clears on the sweep where the average first reaches ≥ 12'h840.
- **Averaging:** samples 12'hFFF, 12'h000, 12'hFFF, 12'h001. Expect `batt_avg`=12'h7FF (sum 14'h1FFF >> 2), with no overflow.
- **Abort:** drop `pwr_up` 10 cycles after the second `nxt`. Expect no further `nxt`, no `ld_vld`, and `batt_low` unchanged. Raise `pwr_up`: the first `nxt` comes 2^14 cycles later.
- **Async reset:** assert `rst_n` mid-GAP. All outputs are 0 immediately, with no clock edge needed.
